alu_result_checker: RTL
=======================

# alu_result_checker

Synthesizable response checker that sits on the output side of the 32-bit ALU and consumes `ALUresult`, `zero`, `overflow` and `carryOut`.

- Expected responses are queued ahead of time through a valid/ready port into a small FIFO.
- Each ALU result strobe pops one expected entry and compares it against the ALU outputs.
- The block keeps pass, fail and orphan counts and captures the first failure.
- It replaces `$monitor`-style inspection in on-chip self-test of the MIPS datapath.

## Interface
Parameters:
- `WIDTH`, default 32: ALU result width.
- `DEPTH`, default 4: expected-entry FIFO depth; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of FIFO, counters and capture.
- `exp_valid`  in  1  expected entry offered.
- `exp_ready`  out  1  FIFO can accept an entry.
- `exp_result`  in  WIDTH  expected ALUresult.
- `exp_flags`  in  3  expected flags: [2] carryOut, [1] overflow, [0] zero.
- `exp_mask`  in  3  per-flag compare enable, same bit order; 1 means compare.
- `res_valid`  in  1  ALU outputs valid this cycle.
- `ALUresult`  in  WIDTH  ALU result.
- `zero`, `overflow`, `carryOut`  in  1 each  ALU flags.
- `pass_count`  out  16  saturating pass counter.
- `fail_count`  out  16  saturating fail counter.
- `orphan_count`  out  8  saturating count of results that arrived with the FIFO empty.
- `mismatch`  out  1  one-cycle pulse per failed compare.
- `first_fail_valid`  out  1  first-failure capture is held.
- `first_fail_index`  out  16  compare index of the first failure.
- `first_fail_result`  out  WIDTH  ALUresult captured at the first failure.

## Operation
**FIFO**
- Each entry holds {exp_result, exp_flags, exp_mask}, `WIDTH`+6 bits.
- Read and write pointers wrap modulo `DEPTH`; the occupancy counter runs 0..`DEPTH`.
- `exp_ready` = (occupancy != `DEPTH`), derived combinationally from registered occupancy.
- An entry is pushed when `exp_valid` && `exp_ready`.

**Compare**
- On `res_valid` with occupancy > 0:
  - Pop the head entry.
  - Pass = (`ALUresult` == exp_result) && ((({carryOut,overflow,zero} ^ exp_flags) & exp_mask) == 0).
  - On pass: increment `pass_count`.
  - On fail: increment `fail_count` and pulse `mismatch`.
- On `res_valid` with occupancy == 0: increment `orphan_count`; no compare occurs.
- Compare index = `pass_count` + `fail_count`, taken before the update.
- First failure only, and only while `first_fail_valid` == 0:
  - latch the compare index and `ALUresult`;
  - set `first_fail_valid`, which then holds until reset or clear.

**Simultaneous events**
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Push on full is blocked by `exp_ready` = 0; a pop that cycle frees a slot, usable from the next cycle.
- Push and `res_valid` in the same cycle with an empty FIFO: the result is an orphan and the entry is pushed. There is no bypass.
- `clear` has priority over push and pop in the same cycle: FIFO goes empty and all counters and capture are cleared.

**Counters**
- All counters saturate at their maximum; they never wrap.

## Timing
**Reset**
- On `rst_n` low, effective immediately and asynchronously:
  - occupancy 0, `exp_ready` 1;
  - all counters 0;
  - `mismatch` 0, `first_fail_valid` 0, `first_fail_index` 0, `first_fail_result` 0.
- Reset asserted mid-operation discards queued entries.
- The first push is accepted on the first rising edge after `rst_n` deasserts.

**Latency**
- Push is visible in occupancy and `exp_ready` the cycle after the accepting edge.
- Compare result: counters, `mismatch` and capture update at the edge that samples `res_valid`, so they are visible 1 cycle after the `res_valid` cycle.
- `mismatch` is high for exactly one cycle per failure; back-to-back failures hold it high.
- `exp_ready` can rise the cycle after a pop from full.

**Interface requirements**
- ALU inputs are sampled only when `res_valid` = 1 and need not be stable otherwise.

## Test plan
1. **Single pass:** push exp_result 0x14, flags 000, mask 111; then `res_valid` with `ALUresult` 0x14, all flags 0 → `pass_count` 1, `fail_count` 0, `mismatch` stays 0.
2. **Mismatch capture:** push 0x0A, mask 111; then result 0x05 → `fail_count` 1, `mismatch` pulses one cycle, `first_fail_valid` 1, index 0, `first_fail_result` 0x05. A second failure leaves the capture unchanged.
3. **Flag mask:** push 0xFFFFFFFE, flags 100, mask 011; then result 0xFFFFFFFE with carryOut 0 → pass. Repeat with mask 111 → fail.
4. **Full and back-pressure:** hold `exp_valid` for 5 entries with `DEPTH` 4 → `exp_ready` 0 after the 4th and the 5th is held. One `res_valid` → 5th accepted on the following edge, occupancy 4.
5. **Orphan:** `res_valid` on empty FIFO → `orphan_count` 1, pass and fail counts unchanged. Simultaneous push and `res_valid` on empty → `orphan_count` 2, occupancy 1.
6. **Reset and clear mid-operation:**
   - With 3 entries queued and `pass_count` 2, assert `rst_n` low between edges → all outputs at reset values before the next edge.
   - Repeat with `clear` plus a simultaneous push → occupancy 0.

Source files
------------

// File: rtl/alu_result_checker.sv
// alu_result_checker: queues expected ALU responses in a small FIFO and
// compares them, in order, against ALU result strobes. Keeps saturating
// pass/fail/orphan counters and captures the first failing compare.
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [WIDTH-1:0] exp_result,
  input  logic [2:0]       exp_flags,
  input  logic [2:0]       exp_mask,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] ALUresult,
  input  logic             zero,
  input  logic             overflow,
  input  logic             carryOut,
  output logic [15:0]      pass_count,
  output logic [15:0]      fail_count,
  output logic [7:0]       orphan_count,
  output logic             mismatch,
  output logic             first_fail_valid,
  output logic [15:0]      first_fail_index,
  output logic [WIDTH-1:0] first_fail_result
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 6;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  // Expected-entry storage: {result, flags, mask}
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [15:0]      pass_q, pass_d;
  logic [15:0]      fail_q, fail_d;
  logic [7:0]       orphan_q, orphan_d;
  logic             mismatch_q, mismatch_d;
  logic             ff_valid_q, ff_valid_d;
  logic [15:0]      ff_index_q, ff_index_d;
  logic [WIDTH-1:0] ff_result_q, ff_result_d;

  logic             push;
  logic             pop;
  logic             orphan;
  logic             cmp_pass;
  logic [EW-1:0]    head;
  logic [WIDTH-1:0] head_result;
  logic [2:0]       head_flags;
  logic [2:0]       head_mask;
  logic [2:0]       obs_flags;
  logic [15:0]      cmp_index;

  assign exp_ready   = (occ_q != OCC_FULL);
  assign push        = exp_valid && exp_ready;
  assign pop         = res_valid && (occ_q != '0);
  // A result with nothing queued is counted as an orphan; a push in the
  // same cycle is not forwarded to it.
  assign orphan      = res_valid && (occ_q == '0);

  assign head        = mem_q[rd_ptr_q];
  assign head_result = head[EW-1:6];
  assign head_flags  = head[5:3];
  assign head_mask   = head[2:0];
  assign obs_flags   = {carryOut, overflow, zero};
  assign cmp_pass    = (ALUresult == head_result) &&
                       (((obs_flags ^ head_flags) & head_mask) == 3'b000);
  assign cmp_index   = pass_q + fail_q;

  // Entry storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= {exp_result, exp_flags, exp_mask};
    end
  end

  // Next-state for pointers, occupancy, counters and first-failure capture
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    orphan_d    = orphan_q;
    mismatch_d  = 1'b0;
    ff_valid_d  = ff_valid_q;
    ff_index_d  = ff_index_q;
    ff_result_d = ff_result_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      pass_d      = '0;
      fail_d      = '0;
      orphan_d    = '0;
      ff_valid_d  = 1'b0;
      ff_index_d  = '0;
      ff_result_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + (AW+1)'(1);
        2'b01:   occ_d = occ_q - (AW+1)'(1);
        default: occ_d = occ_q;
      endcase
      if (orphan && (orphan_q != 8'hFF)) orphan_d = orphan_q + 8'd1;
      if (pop && cmp_pass && (pass_q != 16'hFFFF)) pass_d = pass_q + 16'd1;
      if (pop && !cmp_pass) begin
        if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
        mismatch_d = 1'b1;
        if (!ff_valid_q) begin
          ff_valid_d  = 1'b1;
          ff_index_d  = cmp_index;
          ff_result_d = ALUresult;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      orphan_q    <= '0;
      mismatch_q  <= 1'b0;
      ff_valid_q  <= 1'b0;
      ff_index_q  <= '0;
      ff_result_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      orphan_q    <= orphan_d;
      mismatch_q  <= mismatch_d;
      ff_valid_q  <= ff_valid_d;
      ff_index_q  <= ff_index_d;
      ff_result_q <= ff_result_d;
    end
  end

  assign pass_count        = pass_q;
  assign fail_count        = fail_q;
  assign orphan_count      = orphan_q;
  assign mismatch          = mismatch_q;
  assign first_fail_valid  = ff_valid_q;
  assign first_fail_index  = ff_index_q;
  assign first_fail_result = ff_result_q;

endmodule
